// File: rtl/spi_slave_if_if.sv
// Pin-side and bus-side signal bundle for the SPI responder.
// The slave modport is the responder's view; master is the driver/bus view.
interface spi_slave_if_if #(
  parameter int unsigned WIDTH = 8
);
  logic [1:0]       i_mode;
  logic             i_sclk;
  logic             i_cs_n;
  logic             i_mosi;
  logic             o_miso;
  logic             o_miso_oe;
  logic [WIDTH-1:0] i_tx_data;
  logic             i_tx_valid;
  logic             o_tx_ready;
  logic [WIDTH-1:0] o_rx_data;
  logic             o_rx_valid;
  logic             o_busy;

  modport slave (
    input  i_mode, i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
    output o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy
  );

  modport master (
    output i_mode, i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
    input  o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy
  );
endinterface

// File: rtl/spi_slave_if.sv
// Oversampled SPI responder, all four CPOL/CPHA modes, MSB first, one-word TX buffer.
// Optional macro SPI_SLV_UNDERRUN_EN adds o_tx_underrun (pulse when DEFAULT_TX is loaded).
module spi_slave_if #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TX = WIDTH'(8'hFF)
) (
  input  logic           i_clk,
  input  logic           i_rst,
`ifdef SPI_SLV_UNDERRUN_EN
  output logic           o_tx_underrun,
`endif
  spi_slave_if_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  logic       sclk_rise_q;
  logic       sclk_fall_q;
  logic       cs_fall_q;
  logic       cs_rise_q;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] tx_sh_q;
  logic [WIDTH-1:0] rx_sh_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] buf_q;
  logic             tx_ready_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             miso_q;
  logic             miso_oe_q;
  logic             busy_q;
`ifdef SPI_SLV_UNDERRUN_EN
  logic             underrun_q;
`endif

  logic             lead_c;
  logic             trail_c;
  logic             sample_c;
  logic             shift_c;
  logic             last_bit_c;
  logic             frame_start_c;
  logic             reload_c;
  logic             consume_c;
  logic             load_c;
  logic [WIDTH-1:0] tx_word_d;

  // Synchronisers plus registered edge pulses (pin to pulse = 3 cycles)
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sclk_q      <= '0;
      cs_q        <= '1;
      mosi_q      <= '0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[1:0], bus.i_sclk};
      cs_q        <= {cs_q[1:0], bus.i_cs_n};
      mosi_q      <= {mosi_q[0], bus.i_mosi};
      sclk_rise_q <= sclk_q[1] & ~sclk_q[2];
      sclk_fall_q <= ~sclk_q[1] & sclk_q[2];
      cs_fall_q   <= ~cs_q[1] & cs_q[2];
      cs_rise_q   <= cs_q[1] & ~cs_q[2];
    end
  end

  // Edge roles from the latched mode, and TX word selection
  always_comb begin
    lead_c        = mode_q[1] ? sclk_fall_q : sclk_rise_q;
    trail_c       = mode_q[1] ? sclk_rise_q : sclk_fall_q;
    sample_c      = mode_q[0] ? trail_c : lead_c;
    shift_c       = mode_q[0] ? lead_c : trail_c;
    last_bit_c    = (cnt_q == CW'(WIDTH - 1));
    frame_start_c = (state_q == IDLE) && cs_fall_q;
    reload_c      = (state_q == ACTIVE) && !cs_rise_q && sample_c && last_bit_c;
    consume_c     = frame_start_c || reload_c;
    load_c        = bus.i_tx_valid && tx_ready_q;
    tx_word_d     = tx_ready_q ? DEFAULT_TX : buf_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      tx_ready_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SPI_SLV_UNDERRUN_EN
      underrun_q <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
`ifdef SPI_SLV_UNDERRUN_EN
      underrun_q <= consume_c && tx_ready_q;
`endif
      // A consume only frees a full buffer; a load only fills an empty one
      if (consume_c && !tx_ready_q) begin
        tx_ready_q <= 1'b1;
      end
      if (load_c) begin
        buf_q      <= bus.i_tx_data;
        tx_ready_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cs_fall_q) begin
            state_q   <= ACTIVE;
            mode_q    <= bus.i_mode;
            cnt_q     <= '0;
            rx_sh_q   <= '0;
            busy_q    <= 1'b1;
            miso_oe_q <= 1'b1;
            miso_q    <= tx_word_d[WIDTH-1];
            // tx_sh_q MSB is always the next bit to present on a shift edge
            tx_sh_q   <= bus.i_mode[0] ? tx_word_d : {tx_word_d[WIDTH-2:0], 1'b0};
          end
        end
        ACTIVE: begin
          if (cs_rise_q) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
          end else begin
            if (sample_c) begin
              if (last_bit_c) begin
                rx_data_q  <= {rx_sh_q[WIDTH-2:0], mosi_q[1]};
                rx_valid_q <= 1'b1;
                cnt_q      <= '0;
                tx_sh_q    <= tx_word_d;
              end else begin
                rx_sh_q <= {rx_sh_q[WIDTH-2:0], mosi_q[1]};
                cnt_q   <= cnt_q + CW'(1);
              end
            end
            if (shift_c) begin
              miso_q  <= tx_sh_q[WIDTH-1];
              tx_sh_q <= {tx_sh_q[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_miso     = miso_q;
  assign bus.o_miso_oe  = miso_oe_q;
  assign bus.o_tx_ready = tx_ready_q;
  assign bus.o_rx_data  = rx_data_q;
  assign bus.o_rx_valid = rx_valid_q;
  assign bus.o_busy     = busy_q;
`ifdef SPI_SLV_UNDERRUN_EN
  assign o_tx_underrun  = underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: bit-banged SPI master in all modes, TX handshake,
// back-to-back, aborted frame and asynchronous reset.
module tb_spi_slave_if;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned rxv_cyc = 0;
  int unsigned last_samp_cyc = 0;
  logic [7:0]  rx_words[$];
`ifdef SPI_SLV_UNDERRUN_EN
  logic        tx_underrun;
`endif

  spi_slave_if_if #(.WIDTH(8)) bus ();

  spi_slave_if #(.WIDTH(8), .DEFAULT_TX(8'hFF)) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
`ifdef SPI_SLV_UNDERRUN_EN
    .o_tx_underrun (tx_underrun),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.o_rx_valid === 1'b1) begin
      rx_words.push_back(bus.o_rx_data);
      rxv_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    bus.i_tx_data  = d;
    bus.i_tx_valid = 1'b1;
    while (bus.o_tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL load_tx_timeout ready=%b want 1", bus.o_tx_ready);
    end
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
  endtask

  task automatic cs_low(input logic [1:0] mode);
    @(negedge clk);
    bus.i_mode = mode;
    bus.i_sclk = mode[1];
    wait_clks(8);
    bus.i_cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    bus.i_cs_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic master_bits(input logic [1:0] mode, input logic [7:0] mo, input int n,
                             output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - n; i--) begin
      if (!mode[0]) begin
        bus.i_mosi = mo[i];
        wait_clks(HALF);
        bus.i_sclk = ~mode[1];
        mi[i] = bus.o_miso;
        last_samp_cyc = cyc;
        wait_clks(HALF);
        bus.i_sclk = mode[1];
      end else begin
        bus.i_sclk = ~mode[1];
        bus.i_mosi = mo[i];
        wait_clks(HALF);
        bus.i_sclk = mode[1];
        mi[i] = bus.o_miso;
        last_samp_cyc = cyc;
        wait_clks(HALF);
      end
    end
  endtask

  task automatic test_reset();
    wait_clks(3);
    total++; if (bus.o_miso !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b exp=0", bus.o_miso); end
    total++; if (bus.o_miso_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", bus.o_miso_oe); end
    total++; if (bus.o_tx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.o_tx_ready); end
    total++; if (bus.o_rx_data !== 8'h00) begin bad++; $display("FAIL rst_rxdata got=%h exp=00", bus.o_rx_data); end
    total++; if (bus.o_rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rxvalid got=%b exp=0", bus.o_rx_valid); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.o_busy); end
    rst_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_mode3();
    logic [7:0] mi;
    rx_words.delete();
    load_tx(8'h8D);
    total++; if (bus.o_tx_ready !== 1'b0) begin bad++; $display("FAIL m3_ready_full got=%b exp=0", bus.o_tx_ready); end
    cs_low(2'b11);
    total++; if (bus.o_tx_ready !== 1'b1) begin bad++; $display("FAIL m3_ready_after_cs got=%b exp=1", bus.o_tx_ready); end
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL m3_busy got=%b exp=1", bus.o_busy); end
    total++; if (bus.o_miso_oe !== 1'b1) begin bad++; $display("FAIL m3_oe got=%b exp=1", bus.o_miso_oe); end
    master_bits(2'b11, 8'hDB, 8, mi);
    cs_high();
    total++; if (mi !== 8'h8D) begin bad++; $display("FAIL m3_miso got=%h exp=8d", mi); end
    total++; if (rx_words.size() != 1) begin bad++; $display("FAIL m3_rx_count got=%0d exp=1", rx_words.size()); end
    else begin
      total++; if (rx_words[0] !== 8'hDB) begin bad++; $display("FAIL m3_rx_data got=%h exp=db", rx_words[0]); end
    end
    total++; if (rxv_cyc - last_samp_cyc != 4) begin bad++; $display("FAIL m3_latency got=%0d exp=4", rxv_cyc - last_samp_cyc); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL m3_busy_end got=%b exp=0", bus.o_busy); end
    total++; if (bus.o_miso_oe !== 1'b0) begin bad++; $display("FAIL m3_oe_end got=%b exp=0", bus.o_miso_oe); end
  endtask

  task automatic test_modes();
    logic [7:0] mi;
    for (int m = 0; m < 3; m++) begin
      rx_words.delete();
      load_tx(8'hA5);
      cs_low(2'(m));
      master_bits(2'(m), 8'h3C, 8, mi);
      cs_high();
      total++; if (mi !== 8'hA5) begin bad++; $display("FAIL mode%0d_miso got=%h exp=a5", m, mi); end
      total++; if (rx_words.size() != 1) begin bad++; $display("FAIL mode%0d_rx_count got=%0d exp=1", m, rx_words.size()); end
      else begin
        total++; if (rx_words[0] !== 8'h3C) begin bad++; $display("FAIL mode%0d_rx_data got=%h exp=3c", m, rx_words[0]); end
      end
    end
  endtask

  task automatic test_no_tx();
    logic [7:0] mi;
    rx_words.delete();
    total++; if (bus.o_tx_ready !== 1'b1) begin bad++; $display("FAIL notx_ready got=%b exp=1", bus.o_tx_ready); end
    cs_low(2'b00);
    master_bits(2'b00, 8'h55, 8, mi);
    cs_high();
    total++; if (mi !== 8'hFF) begin bad++; $display("FAIL notx_miso got=%h exp=ff", mi); end
    total++; if (rx_words.size() != 1) begin bad++; $display("FAIL notx_rx_count got=%0d exp=1", rx_words.size()); end
    else begin
      total++; if (rx_words[0] !== 8'h55) begin bad++; $display("FAIL notx_rx_data got=%h exp=55", rx_words[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1;
    logic [7:0] mi2;
    rx_words.delete();
    load_tx(8'h11);
    cs_low(2'b00);
    fork
      master_bits(2'b00, 8'hC3, 8, mi1);
      begin
        wait_clks(40);
        load_tx(8'h22);
      end
    join
    master_bits(2'b00, 8'h7E, 8, mi2);
    cs_high();
    total++; if (mi1 !== 8'h11) begin bad++; $display("FAIL b2b_miso1 got=%h exp=11", mi1); end
    total++; if (mi2 !== 8'h22) begin bad++; $display("FAIL b2b_miso2 got=%h exp=22", mi2); end
    total++; if (rx_words.size() != 2) begin bad++; $display("FAIL b2b_rx_count got=%0d exp=2", rx_words.size()); end
    else begin
      total++; if (rx_words[0] !== 8'hC3) begin bad++; $display("FAIL b2b_rx0 got=%h exp=c3", rx_words[0]); end
      total++; if (rx_words[1] !== 8'h7E) begin bad++; $display("FAIL b2b_rx1 got=%h exp=7e", rx_words[1]); end
    end
  endtask

  task automatic test_partial();
    logic [7:0] mi;
    rx_words.delete();
    cs_low(2'b01);
    master_bits(2'b01, 8'hF0, 5, mi);
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL part_busy got=%b exp=1", bus.o_busy); end
    cs_high();
    total++; if (rx_words.size() != 0) begin bad++; $display("FAIL part_rx_count got=%0d exp=0", rx_words.size()); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL part_busy_end got=%b exp=0", bus.o_busy); end
    total++; if (bus.o_miso_oe !== 1'b0) begin bad++; $display("FAIL part_oe got=%b exp=0", bus.o_miso_oe); end
    total++; if (bus.o_miso !== 1'b0) begin bad++; $display("FAIL part_miso got=%b exp=0", bus.o_miso); end
    load_tx(8'h96);
    cs_low(2'b01);
    master_bits(2'b01, 8'h69, 8, mi);
    cs_high();
    total++; if (mi !== 8'h96) begin bad++; $display("FAIL part_next_miso got=%h exp=96", mi); end
    total++; if (rx_words.size() != 1) begin bad++; $display("FAIL part_next_count got=%0d exp=1", rx_words.size()); end
    else begin
      total++; if (rx_words[0] !== 8'h69) begin bad++; $display("FAIL part_next_rx got=%h exp=69", rx_words[0]); end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] mi;
    load_tx(8'hC7);
    cs_low(2'b11);
    load_tx(8'h5E);
    master_bits(2'b11, 8'hAA, 3, mi);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", bus.o_busy); end
    total++; if (bus.o_miso_oe !== 1'b0) begin bad++; $display("FAIL arst_oe got=%b exp=0", bus.o_miso_oe); end
    total++; if (bus.o_miso !== 1'b0) begin bad++; $display("FAIL arst_miso got=%b exp=0", bus.o_miso); end
    total++; if (bus.o_tx_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", bus.o_tx_ready); end
    total++; if (bus.o_rx_data !== 8'h00) begin bad++; $display("FAIL arst_rxdata got=%h exp=00", bus.o_rx_data); end
    total++; if (bus.o_rx_valid !== 1'b0) begin bad++; $display("FAIL arst_rxvalid got=%b exp=0", bus.o_rx_valid); end
    bus.i_cs_n = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);
    rx_words.delete();
    load_tx(8'hE1);
    cs_low(2'b00);
    master_bits(2'b00, 8'h1E, 8, mi);
    cs_high();
    total++; if (mi !== 8'hE1) begin bad++; $display("FAIL arst_next_miso got=%h exp=e1", mi); end
    total++; if (rx_words.size() != 1) begin bad++; $display("FAIL arst_next_count got=%0d exp=1", rx_words.size()); end
    else begin
      total++; if (rx_words[0] !== 8'h1E) begin bad++; $display("FAIL arst_next_rx got=%h exp=1e", rx_words[0]); end
    end
  endtask

  initial begin
    bus.i_mode     = 2'b00;
    bus.i_sclk     = 1'b0;
    bus.i_cs_n     = 1'b1;
    bus.i_mosi     = 1'b0;
    bus.i_tx_data  = 8'h00;
    bus.i_tx_valid = 1'b0;
    test_reset();
    test_mode3();
    test_modes();
    test_no_tx();
    test_back_to_back();
    test_partial();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI responder (slave end) for the SPI master path.
- Oversamples the external SCLK, CS_n and MOSI on the system clock.
- Deserialises MOSI into parallel receive words and serialises parallel transmit words onto MISO.
- Supports all four CPOL/CPHA modes, MSB first.
- Sits between the SPI pins and a register/bus side that supplies TX words through a ready/valid handshake and consumes RX words as one-cycle strobes.

Parameters:
- WIDTH, 8, bits per SPI frame.
- DEFAULT_TX, 8'hFF, word shifted out when no TX word is buffered at frame start.

Ports:
- i_clk  input  1  system clock; must be at least 8x SCLK frequency.
- i_rst  input  1  asynchronous, active-low reset.
- i_mode  input  2  {CPOL,CPHA}; sampled only while CS_n is high.
- i_sclk  input  1  SPI serial clock (asynchronous).
- i_cs_n  input  1  chip select, active low (asynchronous).
- i_mosi  input  1  serial data in (asynchronous).
- o_miso  output  1  serial data out.
- o_miso_oe  output  1  MISO output enable; high only while selected.
- i_tx_data  input  WIDTH  word to transmit.
- i_tx_valid  input  1  TX word offered.
- o_tx_ready  output  1  TX holding buffer empty.
- o_rx_data  output  WIDTH  last complete received word.
- o_rx_valid  output  1  one-cycle strobe, new o_rx_data.
- o_busy  output  1  frame in progress.

Behaviour:
- Clock and reset:
  - One clock, i_clk. Reset is asynchronous, active-low on i_rst.
  - Reset values: o_miso=0, o_miso_oe=0, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_busy=0.
  - Reset also clears the TX buffer, both shifters and the bit counter, and forces state IDLE.
- Input synchronisation:
  - i_sclk, i_cs_n and i_mosi each pass through a 2-flop synchroniser.
  - A third flop on SCLK and CS_n provides rise/fall edge detection.
- Edge roles:
  - Leading edge = SCLK transition away from CPOL; trailing edge = transition back to CPOL.
  - CPHA=0: sample on leading edge, shift on trailing edge; bit WIDTH-1 is on MISO from CS_n fall.
  - CPHA=1: shift on leading edge (the first leading edge presents bit WIDTH-1), sample on trailing edge.
- FSM:
  - IDLE -> ACTIVE on synchronised CS_n fall.
    - Load the TX shifter from the buffer if full (buffer empties, o_tx_ready rises next cycle); otherwise load DEFAULT_TX.
    - Clear the bit counter; o_busy=1; o_miso_oe=1.
  - ACTIVE:
    - On each sample edge, shift the synchronised MOSI into the RX shifter LSB and increment the counter.
    - When the counter reaches WIDTH: copy the RX shifter to o_rx_data, pulse o_rx_valid for one cycle, reset the counter to 0.
    - Back-to-back frame: at that same cycle, reload the TX shifter as at frame start; CS_n stays low.
  - ACTIVE -> IDLE on synchronised CS_n rise.
    - o_busy=0, o_miso_oe=0, o_miso=0.
    - A partial word (counter != 0) is discarded with no o_rx_valid; the TX buffer is unchanged.
- Latency: o_rx_valid asserts 4 i_clk cycles after the final sample edge at the pin (2 sync + 1 edge detect + 1 register).
- TX handshake:
  - Transfer occurs when i_tx_valid && o_tx_ready; o_tx_ready falls the next cycle.
  - A load and a frame-start consume in the same cycle: the shifter takes the old buffer content (or DEFAULT_TX if empty), and the new word is stored in the buffer.
- i_mode changes while o_busy=1 are ignored; the mode is latched at CS_n fall.
- SCLK edges while CS_n is high are ignored.

Optional Feature:
- Macro SPI_SLV_UNDERRUN_EN.
- Defined: adds output port o_tx_underrun (1 bit, reset 0), which pulses for one cycle whenever a frame start or back-to-back reload loads DEFAULT_TX because the buffer is empty.
- Undefined: port and logic absent; DEFAULT_TX is substituted silently.

Test Plan:
- Mode 3, TX buffer preloaded 8'h8D, master sends 8'hDB -> MISO carries 8'h8D MSB first; o_rx_valid pulses once with o_rx_data=8'hDB; o_tx_ready returns to 1 after CS_n fall.
- Modes 0, 1, 2 each, TX 8'hA5, master sends 8'h3C -> correct sample/shift edges; MISO 8'hA5, o_rx_data=8'h3C in every mode.
- No TX loaded, master sends 8'h55 -> MISO 8'hFF; o_rx_data=8'h55; with SPI_SLV_UNDERRUN_EN, o_tx_underrun pulses once.
- Back-to-back: CS_n held low for 16 SCLKs, TX 8'h11 buffered, 8'h22 loaded mid-frame 1, master sends 8'hC3 then 8'h7E -> MISO 8'h11 then 8'h22; two o_rx_valid strobes (8'hC3, 8'h7E).
- CS_n deasserted after 5 bits -> no o_rx_valid; o_busy falls; o_miso_oe=0; next full frame receives correctly.
- i_rst low mid-frame -> all outputs at reset values immediately (asynchronous); after release, a new frame completes normally.
